// File: rtl/vmx_mm_param_if.sv
// rtl/vmx_mm_param_if.sv - memory port bundle between the matrix engine and its word-addressed memory
// Reads are combinational (d_i follows addr); writes land on the rising edge while wr_en is high.
interface vmx_mm_param_if #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int AW = 8
);
  logic [AW-1:0]       addr;
  logic                wr_en;
  logic [N*DW-1:0]     d_i;
  logic [2*N*DW-1:0]   d_o;

  modport master (output addr, output wr_en, output d_o, input d_i);
  modport slave  (input addr, input wr_en, input d_o, output d_i);
endinterface

// File: rtl/vmx_mm_param.sv
// rtl/vmx_mm_param.sv - parametrised NxN unsigned matrix multiply / multiply-accumulate engine
// Loads A, B (and C when accumulating) row by row, computes one C row per cycle, writes rows back.
module vmx_mm_param #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   ctrl,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] b_base,
  input  logic [AW-1:0] c_base,
  output logic [31:0]   flag,
  vmx_mm_param_if.master mem
);
  localparam int RW = N * DW;
  localparam int EW = 2 * DW;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = IW + 2;
  localparam logic [CW-1:0] LAST_N  = CW'(N - 1);
  localparam logic [CW-1:0] LAST_2N = CW'(2 * N - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD_A  = 4'd1,
    S_LOAD_B  = 4'd2,
    S_COMPUTE = 4'd3,
    S_WRITE   = 4'd4,
    S_DONE    = 4'd5,
    S_LOAD_C  = 4'd6
  } state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        ctrl1_q, ctrl1_d;
  logic                        acc_q, acc_d;
  logic                        done_q, done_d;
  logic [AW-1:0]               a_base_q, a_base_d;
  logic [AW-1:0]               b_base_q, b_base_d;
  logic [AW-1:0]               c_base_q, c_base_d;
  logic [N-1:0][N-1:0][DW-1:0] a_q, a_d;
  logic [N-1:0][N-1:0][DW-1:0] b_q, b_d;
  logic [N-1:0][2*RW-1:0]      c_q, c_d;
  logic [EW-1:0]               sum;
  logic                        busy;
  logic                        start;
  logic [IW-1:0]               row;
  logic [IW-1:0]               crow;
  logic                        unused_ctrl;

  assign start       = ctrl[1] & ~ctrl1_q;
  assign row         = cnt_q[IW-1:0];
  assign crow        = cnt_q[IW:1];
  assign unused_ctrl = ^{ctrl[31:3], ctrl[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_LOAD_A;
      end
      S_LOAD_A: if (cnt_q == LAST_N) begin
        state_d = S_LOAD_B;
        cnt_d   = '0;
      end
      S_LOAD_B: if (cnt_q == LAST_N) begin
        state_d = acc_q ? S_LOAD_C : S_COMPUTE;
        cnt_d   = '0;
      end
      S_LOAD_C: if (cnt_q == LAST_2N) begin
        state_d = S_COMPUTE;
        cnt_d   = '0;
      end
      S_COMPUTE: if (cnt_q == LAST_N) begin
        state_d = S_WRITE;
        cnt_d   = '0;
      end
      S_WRITE: if (cnt_q == LAST_N) begin
        state_d = S_DONE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl1_q  <= 1'b0;
      acc_q    <= 1'b0;
      done_q   <= 1'b0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
    end else begin
      ctrl1_q  <= ctrl1_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_base_q <= c_base_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
    end
  end

  // The C row being computed replaces itself, so accumulate reads the preloaded value first.
  always_comb begin
    ctrl1_d  = ctrl[1];
    acc_d    = acc_q;
    done_d   = done_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    c_base_d = c_base_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    sum      = '0;
    case (state_q)
      S_IDLE: if (start) begin
        acc_d    = ctrl[2];
        a_base_d = a_base;
        b_base_d = b_base;
        c_base_d = c_base;
        done_d   = 1'b0;
      end
      S_LOAD_A: a_d[row] = mem.d_i;
      S_LOAD_B: b_d[row] = mem.d_i;
      S_LOAD_C: begin
        if (cnt_q[0]) c_d[crow][2*RW-1:RW] = mem.d_i;
        else          c_d[crow][RW-1:0]    = mem.d_i;
      end
      S_COMPUTE: begin
        for (int j = 0; j < N; j++) begin
          sum = acc_q ? c_q[row][j*EW +: EW] : '0;
          for (int k = 0; k < N; k++) begin
            sum = sum + EW'(a_q[row][k]) * EW'(b_q[k][j]);
          end
          c_d[row][j*EW +: EW] = sum;
        end
      end
      S_WRITE: if (state_d == S_DONE) done_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    mem.addr  = '0;
    mem.wr_en = 1'b0;
    mem.d_o   = '0;
    busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    case (state_q)
      S_LOAD_A: mem.addr = a_base_q + AW'(cnt_q);
      S_LOAD_B: mem.addr = b_base_q + AW'(cnt_q);
      S_LOAD_C: mem.addr = c_base_q + AW'(cnt_q);
      S_WRITE: begin
        mem.wr_en = 1'b1;
        mem.addr  = c_base_q + AW'({cnt_q, 1'b0});
        mem.d_o   = c_q[row];
      end
      default: ;
    endcase
    flag = {23'd0, done_q, 3'd0, busy, state_q};
  end
endmodule

// File: tb/tb_vmx_mm_param.sv
// tb/tb_vmx_mm_param.sv - scoreboard bench for vmx_mm_param against a plain matrix-arithmetic model
module tb_vmx_mm_param;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 8;

  typedef struct {
    logic [7:0]   addr;
    logic [127:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl;
  logic [31:0] flag;
  logic [7:0]  a_base, b_base, c_base;
  logic [63:0] mem [0:255];
  logic [31:0] exp_c [0:N-1][0:N-1];
  wr_t         exp_q[$];
  wr_t         mon_e;
  int          checks = 0;
  int          errors = 0;

  vmx_mm_param_if #(.N(N), .DW(DW), .AW(AW)) bus();

  vmx_mm_param #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .a_base(a_base), .b_base(b_base),
    .c_base(c_base), .flag(flag), .mem(bus)
  );

  always #5 clk = ~clk;
  assign bus.d_i = mem[bus.addr];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, expected no write", bus.addr, bus.d_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", bus.addr, mon_e.addr);
        chk("wr_data", bus.d_o, mon_e.data);
      end
    end
  end

  task automatic tick();
    logic [7:0] wa;
    @(posedge clk);
    @(negedge clk);
    if (bus.wr_en === 1'b1) begin
      wa = bus.addr;
      mem[wa] = bus.d_o[63:0];
      wa = wa + 8'd1;
      mem[wa] = bus.d_o[127:64];
    end
  endtask

  function automatic logic [63:0] row4(input logic [15:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic logic [15:0] ael(input logic [7:0] base, input int i, input int k);
    logic [7:0]  ad;
    logic [63:0] w;
    ad = base + 8'(i);
    w  = mem[ad];
    return w[k*16 +: 16];
  endfunction

  function automatic logic [31:0] cel(input logic [7:0] base, input int i, input int j);
    logic [7:0]   ad;
    logic [127:0] r;
    ad = base + 8'(2 * i);
    r[63:0] = mem[ad];
    ad = ad + 8'd1;
    r[127:64] = mem[ad];
    return r[j*32 +: 32];
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
  endtask

  task automatic fill_identity(input logic [7:0] base);
    logic [7:0] ad;
    for (int i = 0; i < N; i++) begin
      ad = base + 8'(i);
      mem[ad] = row4(16'(i == 0), 16'(i == 1), 16'(i == 2), 16'(i == 3));
    end
  endtask

  task automatic prep(input bit acc, input logic [7:0] ab, bb, cb);
    wr_t w;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        longint unsigned s;
        s = acc ? longint'(cel(cb, i, j)) : 64'd0;
        for (int k = 0; k < N; k++) s = s + longint'(ael(ab, i, k)) * longint'(ael(bb, k, j));
        exp_c[i][j] = s[31:0];
      end
    end
    for (int i = 0; i < N; i++) begin
      w.addr = cb + 8'(2 * i);
      for (int j = 0; j < N; j++) w.data[j*32 +: 32] = exp_c[i][j];
      exp_q.push_back(w);
    end
  endtask

  // mode 0: single-cycle start pulse, 1: hold start high for 40 cycles, 2: extra pulse during LOAD_B
  task automatic run(input bit acc, input logic [7:0] ab, bb, cb, input int mode, input string tag);
    int          codes[$];
    logic [7:0]  addrs[$];
    int          done_at;
    int          c;
    logic [31:0] ef;
    for (int k = 0; k < N; k++) begin codes.push_back(1); addrs.push_back(ab + 8'(k)); end
    for (int k = 0; k < N; k++) begin codes.push_back(2); addrs.push_back(bb + 8'(k)); end
    if (acc) for (int m = 0; m < 2*N; m++) begin codes.push_back(6); addrs.push_back(cb + 8'(m)); end
    for (int k = 0; k < N; k++) begin codes.push_back(3); addrs.push_back(8'd0); end
    for (int k = 0; k < N; k++) begin codes.push_back(4); addrs.push_back(cb + 8'(2 * k)); end
    codes.push_back(5);
    addrs.push_back(8'd0);
    prep(acc, ab, bb, cb);
    a_base  = ab;
    b_base  = bb;
    c_base  = cb;
    ctrl    = 32'h0;
    ctrl[2] = acc;
    ctrl[1] = 1'b1;
    done_at = -1;
    for (int s = 0; s < codes.size(); s++) begin
      tick();
      c     = codes[s];
      ef    = 32'(c);
      ef[4] = (c != 5);
      ef[8] = (c == 5);
      chk($sformatf("%s_flag[%0d]", tag, s), flag, ef);
      chk($sformatf("%s_addr[%0d]", tag, s), bus.addr, addrs[s]);
      if (flag[3:0] == 4'd5 && done_at < 0) done_at = s;
      if (mode == 0 && s == 0) ctrl[1] = 1'b0;
      if (mode == 2 && s == N) ctrl[1] = 1'b0;
      if (mode == 2 && s == N + 1) ctrl[1] = 1'b1;
    end
    chk({tag, "_done_latency"}, done_at, acc ? 6*N : 4*N);
    tick();
    chk({tag, "_idle_flag"}, flag, 32'h100);
    chk({tag, "_idle_addr"}, bus.addr, 8'd0);
    if (mode == 1) begin
      for (int t = codes.size() + 1; t < 40; t++) tick();
      chk({tag, "_hold_flag"}, flag, 32'h100);
    end
    ctrl[1] = 1'b0;
    tick();
    chk({tag, "_pending_writes"}, exp_q.size(), 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s_mem_c[%0d][%0d]", tag, i, j), cel(cb, i, j), exp_c[i][j]);
  endtask

  task automatic reset_during(input logic [3:0] code, input string tag);
    bit found;
    fill_random();
    prep(1'b0, 8'h00, 8'h04, 8'h08);
    a_base  = 8'h00;
    b_base  = 8'h04;
    c_base  = 8'h08;
    ctrl    = 32'h2;
    tick();
    ctrl[1] = 1'b0;
    found   = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (flag[3:0] == code) found = 1'b1;
      else tick();
    end
    chk({tag, "_reached"}, found, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_flag"}, flag, 32'h0);
    chk({tag, "_wr_en"}, bus.wr_en, 1'b0);
    chk({tag, "_addr"}, bus.addr, 8'd0);
    chk({tag, "_d_o"}, bus.d_o, 128'd0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk({tag, "_after_flag"}, flag, 32'h0);
  endtask

  initial begin
    rst    = 1'b1;
    ctrl   = 32'h0;
    a_base = 8'h00;
    b_base = 8'h00;
    c_base = 8'h00;
    fill_random();
    tick();
    tick();
    chk("reset_flag", flag, 32'h0);
    chk("reset_addr", bus.addr, 8'd0);
    chk("reset_wr_en", bus.wr_en, 1'b0);
    chk("reset_d_o", bus.d_o, 128'd0);
    rst = 1'b0;
    tick();

    mem[0] = row4(1, 2, 3, 4);
    mem[1] = row4(5, 6, 7, 8);
    mem[2] = row4(4, 3, 2, 1);
    mem[3] = row4(8, 7, 6, 5);
    fill_identity(8'h04);
    run(1'b0, 8'h00, 8'h04, 8'h08, 0, "ident");
    chk("ident_row0_e3", cel(8'h08, 0, 3), 32'd4);

    for (int i = 0; i < 8; i++) mem[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    run(1'b0, 8'h00, 8'h04, 8'h08, 0, "wrap");
    chk("wrap_c11", cel(8'h08, 1, 1), 32'hFFF80004);

    fill_identity(8'h00);
    fill_identity(8'h04);
    for (int i = 8; i < 16; i++) mem[i] = {32'd10, 32'd10};
    run(1'b1, 8'h00, 8'h04, 8'h08, 0, "accum");
    chk("accum_diag", cel(8'h08, 2, 2), 32'd11);
    chk("accum_off", cel(8'h08, 2, 1), 32'd10);

    fill_random();
    run(1'b0, 8'h10, 8'h20, 8'h30, 1, "hold");
    fill_random();
    run(1'b0, 8'h40, 8'h50, 8'h60, 2, "pulse");

    reset_during(4'd3, "rst_compute");
    reset_during(4'd4, "rst_write");
    fill_random();
    run(1'b1, 8'h00, 8'h04, 8'h08, 0, "post_rst");

    fill_random();
    run(1'($urandom_range(0, 1)), 8'hFE, 8'h10, 8'h20, 0, "abase_wrap");

    for (int r = 0; r < 6; r++) begin
      fill_random();
      run(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom), 0,
          $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
